scan_chain_tx: RTL and testbench

SCAN_CHAIN_TX -- requirements
Module: scan_chain_tx

---
 rtl/scan_chain_tx.sv | 156 +++++++++++++++
 tb/tb_scan_chain_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_tx.sv
// scan_chain_tx: serial scan-chain transmitter.
// Shifts a WIDTH-bit word out MSB first on scan_in_o. Each bit gets DIV cycles
// with scan_clk_o low, then DIV cycles with it high. A DIV-cycle scan_load_o
// strobe follows the last bit.
// Optional macro SCAN_CHAIN_TX_IOB_REG_EN adds one output register stage on
// scan_in_o, scan_clk_o and scan_load_o so they can be packed into I/O cells.
module scan_chain_tx #(
    parameter int WIDTH = 16,
    parameter int DIV   = 2
) (
    input  logic             pl_clk1,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             scan_in_o,
    output logic             scan_clk_o,
    output logic             scan_load_o
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DIV + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LOAD     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             done_q, done_d;

    logic             phase_last;
    logic             bit_last;
    logic             scan_in_d, scan_clk_d, scan_load_d;

    assign phase_last = (phase_q == PW'(DIV - 1));
    assign bit_last   = (bit_cnt_q == BW'(WIDTH - 1));

    // State, shift register, counters and done pulse; reset wins over everything.
    always_ff @(posedge pl_clk1) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: phase counter paces each half period, bit counter ends the word, abort forces IDLE.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d   = '0;
                bit_cnt_d = '0;
                if (start_i && !abort_i) begin
                    shreg_d = data_i;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = SHIFT_HI;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    phase_d   = '0;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    state_d   = bit_last ? LOAD : SHIFT_LO;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            LOAD: begin
                if (phase_last) begin
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d   = IDLE;
            phase_d   = '0;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    // Pin values decoded from the current state; data is only driven while shifting.
    always_comb begin
        scan_clk_d  = (state_q == SHIFT_HI);
        scan_load_d = (state_q == LOAD);
        scan_in_d   = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && shreg_q[WIDTH-1];
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

`ifdef SCAN_CHAIN_TX_IOB_REG_EN
    logic scan_in_q, scan_clk_q, scan_load_q;

    // Extra pin register stage so the pins can sit in I/O flops; adds one cycle to pin activity.
    always_ff @(posedge pl_clk1) begin
        if (reset) begin
            scan_in_q   <= 1'b0;
            scan_clk_q  <= 1'b0;
            scan_load_q <= 1'b0;
        end else begin
            scan_in_q   <= scan_in_d;
            scan_clk_q  <= scan_clk_d;
            scan_load_q <= scan_load_d;
        end
    end

    assign scan_in_o   = scan_in_q;
    assign scan_clk_o  = scan_clk_q;
    assign scan_load_o = scan_load_q;
`else
    assign scan_in_o   = scan_in_d;
    assign scan_clk_o  = scan_clk_d;
    assign scan_load_o = scan_load_d;
`endif

endmodule

// File: tb/tb_scan_chain_tx.sv
// tb_scan_chain_tx: scoreboard bench for scan_chain_tx.
// Two instances are exercised: an 8-bit word with DIV=2, and a 4-bit word with DIV=1.
// A transfer-level model predicts the following for each accepted word:
//   - the cycle and data bit at every scan_clk rising edge,
//   - the busy window and the load window,
//   - the done cycle.
// Monitors compare those predictions against what the DUTs present.
module tb_scan_chain_tx;

    localparam int WA = 8;
    localparam int DA = 2;
    localparam int WB = 4;
    localparam int DB = 1;
`ifdef SCAN_CHAIN_TX_IOB_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int   dut;
        int   cyc;
        logic b;
    } bit_exp_t;

    typedef struct {
        int dut;
        int cyc;
    } done_exp_t;

    logic          pl_clk1 = 1'b0;
    logic          reset;
    logic          start_a, abort_a, start_b, abort_b;
    logic [WA-1:0] data_a;
    logic [WB-1:0] data_b;
    logic [1:0]    busy_v, done_v, sin_v, sclk_v, sload_v;
    logic [1:0]    prev_sclk;

    int        cyc = 0;
    int        tests = 0;
    int        fails = 0;
    int        bs[2];
    int        be[2];
    int        ls[2];
    int        le[2];
    bit_exp_t  bit_q[$];
    done_exp_t done_q[$];

    always #5 pl_clk1 = ~pl_clk1;

    scan_chain_tx #(.WIDTH(WA), .DIV(DA)) dut_a (
        .pl_clk1    (pl_clk1),
        .reset      (reset),
        .start_i    (start_a),
        .data_i     (data_a),
        .abort_i    (abort_a),
        .busy_o     (busy_v[0]),
        .done_o     (done_v[0]),
        .scan_in_o  (sin_v[0]),
        .scan_clk_o (sclk_v[0]),
        .scan_load_o(sload_v[0])
    );

    scan_chain_tx #(.WIDTH(WB), .DIV(DB)) dut_b (
        .pl_clk1    (pl_clk1),
        .reset      (reset),
        .start_i    (start_b),
        .data_i     (data_b),
        .abort_i    (abort_b),
        .busy_o     (busy_v[1]),
        .done_o     (done_v[1]),
        .scan_in_o  (sin_v[1]),
        .scan_clk_o (sclk_v[1]),
        .scan_load_o(sload_v[1])
    );

    // Compares one observed value with its expectation and keeps the counters.
    task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, expv);
        end
    endtask

    // Drops predictions that a reset or abort makes void: pins after pin_bound, busy/done after busy_bound.
    task automatic purge(input int d, input int pin_bound, input int busy_bound);
        if (be[d] > busy_bound) be[d] = busy_bound;
        if (le[d] > pin_bound) le[d] = pin_bound;
        for (int i = bit_q.size() - 1; i >= 0; i--)
            if (bit_q[i].dut == d && bit_q[i].cyc > pin_bound) bit_q.delete(i);
        for (int i = done_q.size() - 1; i >= 0; i--)
            if (done_q[i].dut == d && done_q[i].cyc > busy_bound) done_q.delete(i);
    endtask

    // Transfer-level model: inputs seen in cycle c decide what the outputs do from cycle c+1 on.
    task automatic model_step(input int d, input int c);
        logic        st, ab;
        int          w, dv;
        logic [31:0] dat;
        st  = (d == 0) ? start_a : start_b;
        ab  = (d == 0) ? abort_a : abort_b;
        w   = (d == 0) ? WA : WB;
        dv  = (d == 0) ? DA : DB;
        dat = (d == 0) ? 32'(data_a) : 32'(data_b);
        if (reset) begin
            purge(d, c, c);
        end else if (ab) begin
            if (c >= bs[d] && c <= be[d]) purge(d, c + LAT, c);
        end else if (st && c > be[d]) begin
            bs[d] = c + 1;
            be[d] = c + 2 * dv * w + dv;
            ls[d] = be[d] - dv + 1 + LAT;
            le[d] = be[d] + LAT;
            for (int k = 0; k < w; k++)
                bit_q.push_back('{dut: d, cyc: c + 1 + 2 * dv * k + dv + LAT, b: dat[w - 1 - k]});
            done_q.push_back('{dut: d, cyc: be[d] + 1});
        end
    endtask

    // Reference model runs on the same edge that the DUTs sample their inputs.
    always @(posedge pl_clk1) begin
        model_step(0, cyc);
        model_step(1, cyc);
        cyc = cyc + 1;
    end

    // Monitor: checks busy/load windows every cycle, pops scan edge and done expectations on events.
    always @(negedge pl_clk1) begin
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                int idx;
                checkOutput("busy", d, 32'(busy_v[d]), 32'(cyc >= bs[d] && cyc <= be[d]));
                checkOutput("scan_load", d, 32'(sload_v[d]), 32'(cyc >= ls[d] && cyc <= le[d]));
                if (sclk_v[d] && !prev_sclk[d]) begin
                    idx = -1;
                    for (int i = 0; i < bit_q.size(); i++)
                        if (idx < 0 && bit_q[i].dut == d) idx = i;
                    checkOutput("scan_edge_expected", d, 32'(idx >= 0), 32'd1);
                    if (idx >= 0) begin
                        checkOutput("scan_edge_cycle", d, 32'(cyc), 32'(bit_q[idx].cyc));
                        checkOutput("scan_in_bit", d, 32'(sin_v[d]), 32'(bit_q[idx].b));
                        bit_q.delete(idx);
                    end
                end
                if (done_v[d]) begin
                    idx = -1;
                    for (int i = 0; i < done_q.size(); i++)
                        if (idx < 0 && done_q[i].dut == d) idx = i;
                    checkOutput("done_expected", d, 32'(idx >= 0), 32'd1);
                    if (idx >= 0) begin
                        checkOutput("done_cycle", d, 32'(cyc), 32'(done_q[idx].cyc));
                        done_q.delete(idx);
                    end
                end
                prev_sclk[d] = sclk_v[d];
            end
        end
    end

    // Advances n clock edges and returns just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge pl_clk1);
        #1;
    endtask

    // Presents a one-cycle start pulse with the given word, then scrambles data to prove it was latched.
    task automatic applyStimulus(input int d, input logic [31:0] word);
        if (d == 0) begin
            data_a  = word[WA-1:0];
            start_a = 1'b1;
        end else begin
            data_b  = word[WB-1:0];
            start_b = 1'b1;
        end
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = WA'($urandom);
        data_b  = WB'($urandom);
    endtask

    // Pins of one instance must all be quiet.
    task automatic check_pins_quiet(input string tag);
        checkOutput({tag, "_scan_in"}, 0, 32'(sin_v[0]), 32'd0);
        checkOutput({tag, "_scan_clk"}, 0, 32'(sclk_v[0]), 32'd0);
        checkOutput({tag, "_scan_load"}, 0, 32'(sload_v[0]), 32'd0);
    endtask

    // Directed scenarios followed by random traffic, then the leftover-expectation check.
    initial begin
        int cnt_bits, cnt_done;
        for (int d = 0; d < 2; d++) begin
            bs[d] = 0;
            be[d] = -1;
            ls[d] = 0;
            le[d] = -1;
        end
        prev_sclk = 2'b00;
        reset   = 1'b1;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        tick(2);
        reset = 1'b0;
        checkOutput("reset_busy", 0, 32'(busy_v[0]), 32'd0);
        checkOutput("reset_done", 0, 32'(done_v[0]), 32'd0);
        check_pins_quiet("reset");
        tick(2);

        $display("[TB] 0xA5 transfer with ignored 0xFF start mid-way");
        applyStimulus(0, 32'hA5);
        tick(9);
        data_a  = 8'hFF;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(30);

        $display("[TB] abort at bit 3");
        applyStimulus(0, $urandom);
        tick(12);
        abort_a = 1'b1;
        tick(1);
        abort_a = 1'b0;
        checkOutput("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        checkOutput("abort_done", 0, 32'(done_v[0]), 32'd0);
        if (LAT != 0) tick(1);
        check_pins_quiet("abort");
        tick(3);
        applyStimulus(0, $urandom);
        tick(40);

        $display("[TB] reset in the middle of a transfer");
        applyStimulus(0, $urandom);
        tick(19);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("midreset_busy", 0, 32'(busy_v[0]), 32'd0);
        checkOutput("midreset_done", 0, 32'(done_v[0]), 32'd0);
        check_pins_quiet("midreset");
        tick(3);

        $display("[TB] back-to-back words on the 4-bit instance");
        start_b = 1'b1;
        for (int i = 0; i < 45; i++) begin
            data_b = WB'($urandom);
            tick(1);
        end
        start_b = 1'b0;
        tick(12);

        $display("[TB] random start/abort traffic");
        for (int i = 0; i < 400; i++) begin
            start_a = ($urandom_range(0, 5) == 0);
            abort_a = ($urandom_range(0, 59) == 0);
            data_a  = WA'($urandom);
            start_b = ($urandom_range(0, 2) == 0);
            abort_b = ($urandom_range(0, 29) == 0);
            data_b  = WB'($urandom);
            tick(1);
        end
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        tick(50);

        for (int d = 0; d < 2; d++) begin
            cnt_bits = 0;
            cnt_done = 0;
            foreach (bit_q[i]) if (bit_q[i].dut == d) cnt_bits++;
            foreach (done_q[i]) if (done_q[i].dut == d) cnt_done++;
            checkOutput("pending_scan_edges", d, 32'(cnt_bits), 32'd0);
            checkOutput("pending_done", d, 32'(cnt_done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
